// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU operation codes, skid-buffer occupancy encoding
// and the entry layout held by the ID->EX stage.
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ALU_OP_W   = 3;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   typedef struct packed {
      logic [XLEN-1:0]       a;
      logic [XLEN-1:0]       b;
      logic [ALU_OP_W-1:0]   alu_op;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  reg_write;
   } ex_entry_t;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// id_ex_fwd_mux: resolves one source operand at capture time.
//   src_addr       source register index (x0 always reads as zero)
//   rf_data        register-file read value
//   mem_* / wb_*   later-stage results available for forwarding
//   operand        resolved value
// Build option: ID_EX_FWD_EN enables MEM/WB forwarding (MEM wins over WB).
// Without it the MEM/WB inputs are ignored and only x0 is special-cased.
import cpu_pkg::*;

module id_ex_fwd_mux (
   input  logic [REG_ADDR_W-1:0] src_addr,
   input  logic [XLEN-1:0]       rf_data,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]       mem_result,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]       wb_result,
   output logic [XLEN-1:0]       operand
);

`ifndef ID_EX_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{mem_reg_write, mem_rd_addr, mem_result,
                         wb_reg_write, wb_rd_addr, wb_result};
`endif

   always_comb begin
      operand = rf_data;
      if (src_addr == '0)
         operand = '0;
`ifdef ID_EX_FWD_EN
      else if (mem_reg_write && (mem_rd_addr == src_addr))
         operand = mem_result;
      else if (wb_reg_write && (wb_rd_addr == src_addr))
         operand = wb_result;
`endif
      else
         operand = rf_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding, immediate
// select and a 2-entry skid buffer (head drives ex_*, skid holds overflow).
//   clk, rst_n        clock, async active-low reset
//   flush             drop every buffered entry
//   id_*              decode-side offer, id_ready registered
//   mem_*, wb_*       forwarding sources
//   ex_*              head entry toward the ALU, ex_valid qualifies it
// Build option: ID_EX_FWD_EN (see id_ex_fwd_mux).
//
// state     | meaning
// OCC_EMPTY | no valid entry, ex_valid=0
// OCC_ONE   | head valid, skid free
// OCC_TWO   | head and skid valid, id_ready=0
import cpu_pkg::*;

module id_ex_stage (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic                  id_use_imm,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_reg_write,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]       mem_result,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]       wb_result,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [XLEN-1:0]       ex_a,
   output logic [XLEN-1:0]       ex_b,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_reg_write
);

   occ_state_t      state, state_nxt;
   ex_entry_t       head, skid, new_entry;
   logic [XLEN-1:0] rs1_op, rs2_op;
   logic            cap, cons;

   id_ex_fwd_mux u_fwd_rs1 (
      .src_addr      (id_rs1_addr),
      .rf_data       (id_rs1_data),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_result     (wb_result),
      .operand       (rs1_op)
   );

   id_ex_fwd_mux u_fwd_rs2 (
      .src_addr      (id_rs2_addr),
      .rf_data       (id_rs2_data),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_result     (wb_result),
      .operand       (rs2_op)
   );

   assign cap  = id_valid & id_ready;
   assign cons = ex_valid & ex_ready;

   always_comb begin
      new_entry.a         = rs1_op;
      new_entry.b         = id_use_imm ? id_imm : rs2_op;
      new_entry.alu_op    = id_alu_op;
      new_entry.rd_addr   = id_rd_addr;
      new_entry.reg_write = id_reg_write;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OCC_EMPTY: if (cap) state_nxt = OCC_ONE;
         OCC_ONE: begin
            if (cap && !cons)      state_nxt = OCC_TWO;
            else if (!cap && cons) state_nxt = OCC_EMPTY;
         end
         OCC_TWO:   if (cons) state_nxt = OCC_ONE;
         default:   state_nxt = OCC_EMPTY;
      endcase
   end

   // Payload registers are left alone on flush; only ex_valid qualifies them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OCC_EMPTY;
         ex_valid <= 1'b0;
         id_ready <= 1'b1;
         head     <= '0;
         skid     <= '0;
      end else if (flush) begin
         state    <= OCC_EMPTY;
         ex_valid <= 1'b0;
         id_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         ex_valid <= (state_nxt != OCC_EMPTY);
         id_ready <= (state_nxt != OCC_TWO);
         case (state)
            OCC_EMPTY: if (cap) head <= new_entry;
            OCC_ONE: begin
               if (cap && cons) head <= new_entry;
               else if (cap)    skid <= new_entry;
            end
            OCC_TWO:   if (cons) head <= skid;
            default:   ;
         endcase
      end
   end

   assign ex_a         = head.a;
   assign ex_b         = head.b;
   assign ex_alu_op    = head.alu_op;
   assign ex_rd_addr   = head.rd_addr;
   assign ex_reg_write = head.reg_write;

endmodule
